// File: rtl/tv_runner.sv
// tv_runner: on-chip test-vector runner. Holds a vector memory of packed
// {stimulus, expected} words, drives the stimulus into an external DUT,
// compares the DUT response after DUT_LAT wait cycles and keeps a record
// of the last mismatch plus a saturating error count.
module tv_runner #(
  parameter int unsigned IN_W    = 8,
  parameter int unsigned OUT_W   = 8,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned AW      = 6,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [AW-1:0]          load_addr,
  input  logic [IN_W+OUT_W-1:0]  load_data,
  input  logic [AW:0]            num_vec,
  input  logic                   start,
  output logic [IN_W-1:0]        dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [AW:0]            vec_index,
  output logic [15:0]            err_count,
  output logic                   err_valid,
  output logic [AW:0]            err_index,
  output logic [OUT_W-1:0]       err_got,
  output logic [OUT_W-1:0]       err_exp
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [3:0]  LAT_V   = 4'(DUT_LAT);

  state_t r_state;
  state_t w_state_nxt;

  logic [IN_W+OUT_W-1:0] r_mem [DEPTH];

  logic [IN_W-1:0]  r_dut_in;
  logic [AW:0]      r_vec_index;
  logic [AW:0]      r_nv;
  logic [3:0]       r_wcnt;
  logic [15:0]      r_err_count;
  logic             r_err_valid;
  logic [AW:0]      r_err_index;
  logic [OUT_W-1:0] r_err_got;
  logic [OUT_W-1:0] r_err_exp;

  logic             w_start_acc;
  logic             w_wr;
  logic             w_cmp;
  logic             w_last;
  logic             w_mismatch;
  logic [AW:0]      w_nv_clamped;
  logic [AW-1:0]    w_cur_addr;
  logic [AW-1:0]    w_next_addr;
  logic [AW:0]      w_next_idx;
  logic [OUT_W-1:0] w_cur_exp;
  logic [IN_W-1:0]  w_next_in;
  logic [IN_W-1:0]  w_first_in;

  // Start is honoured only when no run is in progress.
  assign w_start_acc  = start && (r_state != ST_RUN);
  assign w_nv_clamped = (num_vec > DEPTH_V) ? DEPTH_V : num_vec;

  // Loads are blocked during a run and out-of-range slots are dropped.
  assign w_wr = load_en && (r_state != ST_RUN) && ({1'b0, load_addr} < DEPTH_V);

  // Asynchronous memory reads for the current expected and next stimulus.
  assign w_cur_addr  = r_vec_index[AW-1:0];
  assign w_next_addr = r_vec_index[AW-1:0] + AW'(1);
  assign w_next_idx  = r_vec_index + (AW+1)'(1);
  assign w_cur_exp   = r_mem[w_cur_addr][OUT_W-1:0];
  assign w_next_in   = r_mem[w_next_addr][IN_W+OUT_W-1:OUT_W];
  assign w_first_in  = r_mem[0][IN_W+OUT_W-1:OUT_W];

  // A compare edge happens once the wait counter has reached the latency.
  assign w_cmp      = (r_state == ST_RUN) && (r_nv != '0) && (r_wcnt == LAT_V);
  assign w_last     = (r_vec_index == (r_nv - (AW+1)'(1)));
  assign w_mismatch = w_cmp && (dut_out != w_cur_exp);

  // Vector memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[load_addr] <= load_data;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: an empty run leaves RUN on its first edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (r_nv == '0) begin
          w_state_nxt = ST_DONE;
        end else if (w_cmp && w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: done = 1'b1;
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
    pass = done && (r_err_count == '0);
  end

  // Run datapath: stimulus, index, wait counter and mismatch record.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dut_in    <= '0;
      r_vec_index <= '0;
      r_nv        <= '0;
      r_wcnt      <= '0;
      r_err_count <= '0;
      r_err_valid <= 1'b0;
      r_err_index <= '0;
      r_err_got   <= '0;
      r_err_exp   <= '0;
    end else begin
      r_err_valid <= 1'b0;
      if (w_start_acc) begin
        r_nv        <= w_nv_clamped;
        r_vec_index <= '0;
        r_wcnt      <= '0;
        r_err_count <= '0;
        r_dut_in    <= w_first_in;
      end else if ((r_state == ST_RUN) && (r_nv != '0)) begin
        if (!w_cmp) begin
          r_wcnt <= r_wcnt + 4'd1;
        end else begin
          if (w_mismatch) begin
            r_err_valid <= 1'b1;
            r_err_index <= r_vec_index;
            r_err_got   <= dut_out;
            r_err_exp   <= w_cur_exp;
            if (r_err_count != '1) begin
              r_err_count <= r_err_count + 16'd1;
            end
          end
          if (!w_last) begin
            r_vec_index <= w_next_idx;
            r_dut_in    <= w_next_in;
            r_wcnt      <= '0;
          end
        end
      end
    end
  end

  assign dut_in    = r_dut_in;
  assign vec_index = r_vec_index;
  assign err_count = r_err_count;
  assign err_valid = r_err_valid;
  assign err_index = r_err_index;
  assign err_got   = r_err_got;
  assign err_exp   = r_err_exp;

endmodule

// File: tb/tb_tv_runner.sv
// Directed bench for tv_runner: an identity DUT on a zero-latency runner
// and a one-register DUT on a DUT_LAT=1 runner, sharing clock, reset and
// load bus but started independently.
module tb_tv_runner;

  logic        clk;
  logic        reset;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [15:0] load_data;
  logic [6:0]  num_vec;
  logic        start0;
  logic        start1;

  logic [7:0]  dut_in0, dut_out0, dut_in1, dut_out1;
  logic        busy0, done0, pass0, err_valid0;
  logic        busy1, done1, pass1, err_valid1;
  logic [6:0]  vec_index0, err_index0, vec_index1, err_index1;
  logic [15:0] err_count0, err_count1;
  logic [7:0]  err_got0, err_exp0, err_got1, err_exp1;

  int n_checks;
  int n_fail;

  tv_runner #(.IN_W(8), .OUT_W(8), .DEPTH(64), .AW(6), .DUT_LAT(0)) u_run0 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start0),
    .dut_in(dut_in0), .dut_out(dut_out0), .busy(busy0), .done(done0),
    .pass(pass0), .vec_index(vec_index0), .err_count(err_count0),
    .err_valid(err_valid0), .err_index(err_index0), .err_got(err_got0),
    .err_exp(err_exp0)
  );

  tv_runner #(.IN_W(8), .OUT_W(8), .DEPTH(64), .AW(6), .DUT_LAT(1)) u_run1 (
    .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .num_vec(num_vec), .start(start1),
    .dut_in(dut_in1), .dut_out(dut_out1), .busy(busy1), .done(done1),
    .pass(pass1), .vec_index(vec_index1), .err_count(err_count1),
    .err_valid(err_valid1), .err_index(err_index1), .err_got(err_got1),
    .err_exp(err_exp1)
  );

  // Identity DUT and one-cycle register DUT.
  assign dut_out0 = dut_in0;
  always @(posedge clk) dut_out1 <= dut_in1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec(input logic [5:0] a, input logic [15:0] d);
    load_en   = 1'b1;
    load_addr = a;
    load_data = d;
    step();
    load_en   = 1'b0;
  endtask

  task automatic go0(input logic [6:0] n);
    num_vec = n;
    start0  = 1'b1;
    step();
    start0  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    n_checks++; if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0h exp=0", busy0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done got=%0h exp=0", done0); end
    n_checks++; if (pass0 !== 1'b0) begin n_fail++; $display("FAIL rst_pass got=%0h exp=0", pass0); end
    n_checks++; if (dut_in0 !== 8'h00) begin n_fail++; $display("FAIL rst_dut_in got=%0h exp=0", dut_in0); end
    n_checks++; if (err_count0 !== 16'h0) begin n_fail++; $display("FAIL rst_err_count got=%0h exp=0", err_count0); end
    n_checks++; if ({err_valid0, err_index0, err_got0, err_exp0} !== '0) begin
      n_fail++; $display("FAIL rst_err_rec got=%0h exp=0", {err_valid0, err_index0, err_got0, err_exp0}); end
  endtask

  task automatic test_identity();
    for (int i = 0; i < 4; i++) load_vec(6'(i), {8'(i), 8'(i)});
    go0(7'd4);
    n_checks++; if (busy0 !== 1'b1 || dut_in0 !== 8'h00) begin
      n_fail++; $display("FAIL id_entry got busy=%0h dut_in=%0h exp busy=1 dut_in=0", busy0, dut_in0); end
    for (int k = 1; k <= 4; k++) begin
      step();
      n_checks++; if (err_valid0 !== 1'b0) begin n_fail++; $display("FAIL id_err_valid cyc=%0d got=%0h exp=0", k, err_valid0); end
      if (k < 4) begin
        n_checks++; if (busy0 !== 1'b1 || vec_index0 !== 7'(k) || dut_in0 !== 8'(k)) begin
          n_fail++; $display("FAIL id_run cyc=%0d got busy=%0h idx=%0d din=%0h exp busy=1 idx=%0d", k, busy0, vec_index0, dut_in0, k); end
      end
    end
    n_checks++; if (done0 !== 1'b1 || busy0 !== 1'b0 || pass0 !== 1'b1 || err_count0 !== 16'd0) begin
      n_fail++; $display("FAIL id_done got done=%0h busy=%0h pass=%0h errs=%0d exp 1 0 1 0", done0, busy0, pass0, err_count0); end
  endtask

  task automatic test_mismatch();
    load_vec(6'd2, 16'h02FF);
    go0(7'd4);
    step();
    step();
    n_checks++; if (err_valid0 !== 1'b0) begin n_fail++; $display("FAIL mm_early_valid got=%0h exp=0", err_valid0); end
    step();
    n_checks++; if (err_valid0 !== 1'b1) begin n_fail++; $display("FAIL mm_valid got=%0h exp=1", err_valid0); end
    n_checks++; if (err_index0 !== 7'd2 || err_got0 !== 8'h02 || err_exp0 !== 8'hFF || err_count0 !== 16'd1) begin
      n_fail++; $display("FAIL mm_record got idx=%0d got=%0h exp=%0h cnt=%0d exp 2 02 ff 1", err_index0, err_got0, err_exp0, err_count0); end
    step();
    n_checks++; if (err_valid0 !== 1'b0 || done0 !== 1'b1 || pass0 !== 1'b0 || err_count0 !== 16'd1) begin
      n_fail++; $display("FAIL mm_done got valid=%0h done=%0h pass=%0h cnt=%0d exp 0 1 0 1", err_valid0, done0, pass0, err_count0); end
  endtask

  task automatic test_latency1();
    logic [7:0] exp_din [6];
    exp_din[0] = 8'h10; exp_din[1] = 8'h10; exp_din[2] = 8'h11;
    exp_din[3] = 8'h11; exp_din[4] = 8'h12; exp_din[5] = 8'h12;
    for (int i = 0; i < 3; i++) load_vec(6'(i), {8'(8'h10 + i), 8'(8'h10 + i)});
    num_vec = 7'd3;
    start1  = 1'b1;
    step();
    start1  = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) step();
      n_checks++; if (dut_in1 !== exp_din[k] || busy1 !== 1'b1) begin
        n_fail++; $display("FAIL lat1_hold cyc=%0d got din=%0h busy=%0h exp din=%0h busy=1", k, dut_in1, busy1, exp_din[k]); end
    end
    step();
    n_checks++; if (done1 !== 1'b1 || pass1 !== 1'b1 || err_count1 !== 16'd0) begin
      n_fail++; $display("FAIL lat1_done got done=%0h pass=%0h cnt=%0d exp 1 1 0", done1, pass1, err_count1); end
  endtask

  task automatic test_num_vec_zero();
    go0(7'd0);
    n_checks++; if (busy0 !== 1'b1 || err_count0 !== 16'd0) begin
      n_fail++; $display("FAIL nv0_entry got busy=%0h cnt=%0d exp 1 0", busy0, err_count0); end
    step();
    n_checks++; if (done0 !== 1'b1 || pass0 !== 1'b1 || busy0 !== 1'b0 || err_valid0 !== 1'b0) begin
      n_fail++; $display("FAIL nv0_done got done=%0h pass=%0h busy=%0h valid=%0h exp 1 1 0 0", done0, pass0, busy0, err_valid0); end
  endtask

  task automatic test_clamp();
    for (int i = 0; i < 64; i++) load_vec(6'(i), {8'(i), 8'(i)});
    go0(7'd65);
    for (int k = 1; k < 64; k++) step();
    n_checks++; if (busy0 !== 1'b1 || vec_index0 !== 7'd63) begin
      n_fail++; $display("FAIL clamp_last got busy=%0h idx=%0d exp 1 63", busy0, vec_index0); end
    step();
    n_checks++; if (done0 !== 1'b1 || vec_index0 !== 7'd63 || pass0 !== 1'b1) begin
      n_fail++; $display("FAIL clamp_done got done=%0h idx=%0d pass=%0h exp 1 63 1", done0, vec_index0, pass0); end
  endtask

  task automatic test_back_to_back();
    load_vec(6'd1, 16'h0155);
    go0(7'd8);
    step();
    step();
    start0    = 1'b1;
    load_en   = 1'b1;
    load_addr = 6'd5;
    load_data = 16'h05AA;
    step();
    start0    = 1'b0;
    load_en   = 1'b0;
    n_checks++; if (vec_index0 !== 7'd3 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_ignore got idx=%0d busy=%0h exp 3 1", vec_index0, busy0); end
    for (int k = 4; k <= 8; k++) step();
    n_checks++; if (done0 !== 1'b1 || err_count0 !== 16'd1 || err_index0 !== 7'd1 || err_exp0 !== 8'h55) begin
      n_fail++; $display("FAIL b2b_done1 got done=%0h cnt=%0d idx=%0d exp=%0h exp 1 1 1 55", done0, err_count0, err_index0, err_exp0); end
    go0(7'd8);
    n_checks++; if (err_count0 !== 16'd0 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL b2b_restart got cnt=%0d busy=%0h exp 0 1", err_count0, busy0); end
    step();
    step();
    n_checks++; if (err_valid0 !== 1'b1 || err_got0 !== 8'h01) begin
      n_fail++; $display("FAIL b2b_pulse got valid=%0h got=%0h exp 1 01", err_valid0, err_got0); end
    for (int k = 3; k <= 8; k++) step();
    n_checks++; if (done0 !== 1'b1 || err_count0 !== 16'd1 || pass0 !== 1'b0) begin
      n_fail++; $display("FAIL b2b_done2 got done=%0h cnt=%0d pass=%0h exp 1 1 0", done0, err_count0, pass0); end
  endtask

  task automatic test_reset_midrun();
    load_vec(6'd1, 16'h0101);
    load_vec(6'd0, 16'h0077);
    go0(7'd10);
    step();
    n_checks++; if (err_count0 !== 16'd1) begin n_fail++; $display("FAIL rmr_pre got cnt=%0d exp 1", err_count0); end
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    n_checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || dut_in0 !== 8'h00 || err_count0 !== 16'd0 || vec_index0 !== 7'd0) begin
      n_fail++; $display("FAIL rmr_abort got busy=%0h done=%0h din=%0h cnt=%0d idx=%0d exp all 0", busy0, done0, dut_in0, err_count0, vec_index0); end
    n_checks++; if (err_valid0 !== 1'b0 || err_got0 !== 8'h00 || err_exp0 !== 8'h00) begin
      n_fail++; $display("FAIL rmr_rec got valid=%0h got=%0h exp=%0h exp all 0", err_valid0, err_got0, err_exp0); end
    load_vec(6'd0, 16'h0000);
    go0(7'd10);
    for (int k = 1; k < 10; k++) step();
    n_checks++; if (dut_in0 !== 8'h09 || busy0 !== 1'b1) begin
      n_fail++; $display("FAIL rmr_last got din=%0h busy=%0h exp 09 1", dut_in0, busy0); end
    step();
    n_checks++; if (done0 !== 1'b1 || pass0 !== 1'b1 || vec_index0 !== 7'd9) begin
      n_fail++; $display("FAIL rmr_done got done=%0h pass=%0h idx=%0d exp 1 1 9", done0, pass0, vec_index0); end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    num_vec   = '0;
    start0    = 1'b0;
    start1    = 1'b0;
    test_reset();
    test_identity();
    test_mismatch();
    test_latency1();
    test_num_vec_zero();
    test_clamp();
    test_back_to_back();
    test_reset_midrun();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
